wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter PW, default 3, register address width; register count is 2**PW.
REQ-002 Parameter DW, default 8, register data width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0_valid  input  1  ALU writeback request.
REQ-006 req0_addr  input  PW  ALU destination register.
REQ-007 req0_data  input  DW  ALU result.
REQ-008 req0_ready  output  1  ALU request accepted this cycle.
REQ-009 req1_valid, req1_addr, req1_data, req1_ready carry the same meanings for the load unit.
REQ-010 issue_valid  input  1  instruction issued with a register destination.
REQ-011 issue_addr  input  PW  destination of the issued instruction.
REQ-012 rd_addr1, rd_addr2  input  PW  decode-stage source registers.
REQ-013 hazard  output  1  a source register has an outstanding write.
REQ-014 busy  output  2**PW  per-register pending-write bits.
REQ-015 rf_we  output  1  register-file write enable (registered).
REQ-016 rf_waddr  output  PW  register-file write address (registered).
REQ-017 rf_wdata  output  DW  register-file write data (registered).

Function
REQ-018 The block shall arbitrate both requesters onto the single register-file write port using two-way round-robin; one grant per cycle.
REQ-019 A handshake completes when valid and ready are both high; readyN is combinational and high only for the granted requester.
REQ-020 Requesters shall hold valid, addr and data stable until ready; the block shall not rely on valid dropping without a handshake.
REQ-021 If exactly one requester is valid, it shall be granted that cycle regardless of priority state.
REQ-022 If both are valid, the requester not granted most recently shall win; the priority pointer updates only on a completed handshake.
REQ-023 A granted request shall appear on rf_we/rf_waddr/rf_wdata exactly one cycle after the handshake (latency 1).
REQ-024 rf_we shall be low in any cycle following a cycle with no handshake.
REQ-025 busy[issue_addr] shall be set on the edge where issue_valid is high.
REQ-026 busy[rf_waddr] shall be cleared on the edge where rf_we is high, the same edge the register file commits the write.
REQ-027 Set and clear of the same register on the same edge: set wins.
REQ-028 hazard shall be combinational: busy[rd_addr1] OR busy[rd_addr2].
REQ-029 Both requesters targeting the same address shall be serialised in grant order; the later write persists in the register file.
REQ-030 Maximum wait for a continuously valid requester shall be one cycle.

Reset
REQ-031 On reset: rf_we=0, rf_waddr=0, rf_wdata=0, busy=all zero, priority pointer favours req0.
REQ-032 While reset is high: req0_ready=0, req1_ready=0, no handshakes, issue_valid ignored.
REQ-033 Reset mid-operation shall discard any pending output-register write; rf_we is low on the first cycle after reset.

Structure
REQ-034 Shared package cpu_pkg shall hold PW, DW, the register-address typedef and the register-data typedef.
REQ-035 A scoreboard sub-module shall own the busy vector and hazard logic; arbitration and the output register stay in wb_arbiter.

Verification
REQ-036 Only req0 valid, addr=3, data=0x5A -> req0_ready=1 same cycle; next cycle rf_we=1, rf_waddr=3, rf_wdata=0x5A.
REQ-037 Both valid for 4 cycles after reset -> grants in order req0, req1, req0, req1.
REQ-038 issue_valid with addr=5, then rd_addr1=5 -> hazard=1 until the edge where rf_we=1 with rf_waddr=5; hazard=0 in the next cycle.
REQ-039 issue_valid addr=2 on the same edge as rf_we=1 with rf_waddr=2 -> busy[2]=1 afterwards.
REQ-040 Reset asserted the cycle after a handshake -> rf_we=0 and busy=0x00 on the first cycle after reset.
REQ-041 req0 and req1 both target addr=7 with data 0x11 and 0x22 -> two rf_we pulses in grant order; the second one carries the last-granted data.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and the writeback arbiter's
// priority-pointer encoding.
package cpu_pkg;

  localparam int PW = 3;
  localparam int DW = 8;

  typedef logic [PW-1:0] reg_addr_t;
  typedef logic [DW-1:0] reg_data_t;

  // Which requester wins when both are valid.
  typedef enum logic {
    PRIO_REQ0 = 1'b0,
    PRIO_REQ1 = 1'b1
  } prio_t;

endpackage

// File: rtl/wb_arbiter_scoreboard.sv
// Register scoreboard: one pending-write bit per register. It is set when an
// instruction with that destination issues and cleared when the register
// file commits the write. hazard flags a decode-stage source that is still
// pending.
module wb_arbiter_scoreboard #(
  parameter int PW = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [PW-1:0]   issue_addr,
  input  logic            clr_valid,
  input  logic [PW-1:0]   clr_addr,
  input  logic [PW-1:0]   rd_addr1,
  input  logic [PW-1:0]   rd_addr2,
  output logic [2**PW-1:0] busy,
  output logic            hazard
);
  import cpu_pkg::*;

  logic [2**PW-1:0] busy_d;

  // Next busy vector: the clear is applied first so that a same-edge set wins.
  always_comb begin
    busy_d = busy;
    if (clr_valid)   busy_d[clr_addr]   = 1'b0;
    if (issue_valid) busy_d[issue_addr] = 1'b1;
  end

  // Busy register; reset also discards any issue seen while reset is high.
  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_d;
  end

  assign hazard = busy[rd_addr1] | busy[rd_addr2];

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the ALU (req0) and load-unit (req1) writeback
// streams onto the single register-file write port with two-way round-robin.
// A grant is a completed handshake; the winning write is registered and
// reaches the register file one cycle later.
module wb_arbiter #(
  parameter int PW = cpu_pkg::PW,
  parameter int DW = cpu_pkg::DW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [PW-1:0]    req0_addr,
  input  logic [DW-1:0]    req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [PW-1:0]    req1_addr,
  input  logic [DW-1:0]    req1_data,
  output logic             req1_ready,
  input  logic             issue_valid,
  input  logic [PW-1:0]    issue_addr,
  input  logic [PW-1:0]    rd_addr1,
  input  logic [PW-1:0]    rd_addr2,
  output logic             hazard,
  output logic [2**PW-1:0] busy,
  output logic             rf_we,
  output logic [PW-1:0]    rf_waddr,
  output logic [DW-1:0]    rf_wdata
);
  import cpu_pkg::*;

  prio_t          prio_q, prio_d;
  logic           gnt0_p0, gnt1_p0;
  logic           vld_p1;
  logic [PW-1:0]  waddr_p1;
  logic [DW-1:0]  wdata_p1;

  // Grant selection and pointer update. A lone valid requester always wins;
  // on contention the pointer decides. Ready equals grant, so every grant is
  // a handshake and the pointer only moves on a completed transfer.
  always_comb begin
    gnt0_p0 = 1'b0;
    gnt1_p0 = 1'b0;
    prio_d  = prio_q;
    if (!reset) begin
      if (req0_valid && req1_valid) begin
        gnt0_p0 = (prio_q == PRIO_REQ0);
        gnt1_p0 = (prio_q == PRIO_REQ1);
      end else begin
        gnt0_p0 = req0_valid;
        gnt1_p0 = req1_valid;
      end
    end
    if (gnt0_p0)      prio_d = PRIO_REQ1;
    else if (gnt1_p0) prio_d = PRIO_REQ0;
  end

  // Priority pointer register; favours req0 out of reset.
  always_ff @(posedge clk) begin
    if (reset) prio_q <= PRIO_REQ0;
    else       prio_q <= prio_d;
  end

  assign req0_ready = gnt0_p0;
  assign req1_ready = gnt1_p0;

  // ---- stage p0 -> p1: register the granted write for the register file ----
  // Output register; reset drops any write captured in the cycle before it.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
    end else begin
      vld_p1 <= gnt0_p0 | gnt1_p0;
      if (gnt0_p0) begin
        waddr_p1 <= req0_addr;
        wdata_p1 <= req0_data;
      end else if (gnt1_p0) begin
        waddr_p1 <= req1_addr;
        wdata_p1 <= req1_data;
      end
    end
  end

  assign rf_we    = vld_p1;
  assign rf_waddr = waddr_p1;
  assign rf_wdata = wdata_p1;

  wb_arbiter_scoreboard #(
    .PW(PW)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .issue_valid(issue_valid),
    .issue_addr (issue_addr),
    .clr_valid  (vld_p1),
    .clr_addr   (waddr_p1),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .busy       (busy),
    .hazard     (hazard)
  );

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: arbitration order, writeback latency,
// scoreboard set/clear and reset behaviour.
module tb_wb_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [2:0] req0_addr, req1_addr;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       issue_valid;
  logic [2:0] issue_addr;
  logic [2:0] rd_addr1, rd_addr2;
  logic       hazard;
  logic [7:0] busy;
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.PW(3), .DW(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .issue_valid(issue_valid),
    .issue_addr (issue_addr),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .hazard     (hazard),
    .busy       (busy),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are changed and outputs sampled
  // 1 ns after it, then 1 ns more is allowed for combinational settling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 0; req0_addr = 0; req0_data = 0;
    req1_valid = 0; req1_addr = 0; req1_data = 0;
    issue_valid = 0; issue_addr = 0; rd_addr1 = 0; rd_addr2 = 0;

    // Reset: readies held low even with valid requests present.
    step();
    req0_valid = 1; req1_valid = 1;
    settle();
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    step();
    req0_valid = 0; req1_valid = 0;
    reset = 1'b0;
    settle();
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_busy", busy, 8'h00);
    chk("rst_hazard", hazard, 0);

    // Single requester: same-cycle ready, write one cycle later.
    req0_valid = 1; req0_addr = 3; req0_data = 8'h5A;
    settle();
    chk("single_ready0", req0_ready, 1);
    chk("single_ready1", req1_ready, 0);
    step();
    req0_valid = 0;
    settle();
    chk("single_we", rf_we, 1);
    chk("single_waddr", rf_waddr, 3);
    chk("single_wdata", rf_wdata, 8'h5A);
    step();
    chk("single_we_drop", rf_we, 0);

    // Contention from a fresh reset: req0, req1, req0, req1.
    do_reset();
    req0_valid = 1; req0_addr = 1; req0_data = 8'hA1;
    req1_valid = 1; req1_addr = 4; req1_data = 8'hB4;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("rr_ready0_%0d", i), req0_ready, (i % 2 == 0));
      chk($sformatf("rr_ready1_%0d", i), req1_ready, (i % 2 == 1));
      step();
      chk($sformatf("rr_waddr_%0d", i), rf_waddr, (i % 2 == 0) ? 3'd1 : 3'd4);
      chk($sformatf("rr_wdata_%0d", i), rf_wdata, (i % 2 == 0) ? 8'hA1 : 8'hB4);
    end
    // Pointer now favours req0, but a lone req1 still wins immediately.
    req0_valid = 0;
    settle();
    chk("lone1_ready1", req1_ready, 1);
    chk("lone1_ready0", req0_ready, 0);
    step();
    req1_valid = 0;
    chk("lone1_we", rf_we, 1);
    chk("lone1_waddr", rf_waddr, 4);

    // Scoreboard: issue r5, hazard until the write to r5 commits.
    issue_valid = 1; issue_addr = 5;
    step();
    issue_valid = 0; rd_addr1 = 5; rd_addr2 = 0;
    settle();
    chk("sb5_busy", busy, 8'h20);
    chk("sb5_hazard_a", hazard, 1);
    step();
    chk("sb5_hazard_b", hazard, 1);
    req0_valid = 1; req0_addr = 5; req0_data = 8'h77;
    settle();
    chk("sb5_ready0", req0_ready, 1);
    step();
    req0_valid = 0;
    settle();
    chk("sb5_we", rf_we, 1);
    chk("sb5_waddr", rf_waddr, 5);
    chk("sb5_hazard_c", hazard, 1);
    step();
    chk("sb5_hazard_clr", hazard, 0);
    chk("sb5_busy_clr", busy, 8'h00);

    // Hazard through the second read port.
    issue_valid = 1; issue_addr = 6;
    step();
    issue_valid = 0; rd_addr1 = 0; rd_addr2 = 6;
    settle();
    chk("sb6_hazard_rd2", hazard, 1);
    rd_addr2 = 1;
    settle();
    chk("sb6_hazard_other", hazard, 0);
    req1_valid = 1; req1_addr = 6; req1_data = 8'h66;
    step();
    req1_valid = 0;
    step();
    chk("sb6_busy_clr", busy, 8'h00);

    // Set and clear of r2 on the same edge: set wins.
    issue_valid = 1; issue_addr = 2;
    step();
    issue_valid = 0;
    req0_valid = 1; req0_addr = 2; req0_data = 8'h33;
    step();
    req0_valid = 0;
    issue_valid = 1; issue_addr = 2;
    settle();
    chk("sb2_we", rf_we, 1);
    chk("sb2_waddr", rf_waddr, 2);
    step();
    issue_valid = 0;
    chk("sb2_set_wins", busy, 8'h04);

    // Reset the cycle after a handshake: pending write and busy discarded,
    // issue during reset ignored.
    req1_valid = 1; req1_addr = 1; req1_data = 8'h99;
    step();
    req1_valid = 0;
    reset = 1; issue_valid = 1; issue_addr = 3; req0_valid = 1;
    settle();
    chk("midrst_ready0", req0_ready, 0);
    step();
    reset = 0; issue_valid = 0; req0_valid = 0;
    settle();
    chk("midrst_we", rf_we, 0);
    chk("midrst_busy", busy, 8'h00);
    chk("midrst_wdata", rf_wdata, 0);

    // Same destination from both: serialised, last grant's data last.
    req0_valid = 1; req0_addr = 7; req0_data = 8'h11;
    req1_valid = 1; req1_addr = 7; req1_data = 8'h22;
    settle();
    chk("same_ready0", req0_ready, 1);
    step();
    req0_valid = 0;
    settle();
    chk("same_we_a", rf_we, 1);
    chk("same_wdata_a", rf_wdata, 8'h11);
    chk("same_ready1", req1_ready, 1);
    step();
    req1_valid = 0;
    chk("same_we_b", rf_we, 1);
    chk("same_waddr_b", rf_waddr, 7);
    chk("same_wdata_b", rf_wdata, 8'h22);
    step();
    chk("same_we_drop", rf_we, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
